// File: rtl/prog_udp_seq.sv
// prog_udp_seq: run-time-loadable N_IN-input truth table, evaluated on enabled clocks, with
// optional feedback of out as the table MSB. Define UDP_XCOUNT_EN to build the x-hit counter.
module prog_udp_seq #(
   parameter int N_IN   = 4,
   parameter int XCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic              cfg_valid,
   input  logic [1:0]        cfg_data,
   output logic              cfg_ready,
   output logic              cfg_done,
   input  logic              seq_mode,
   input  logic              en,
   input  logic [N_IN-1:0]   in,
   output logic              out,
   output logic              out_x,
   output logic              out_valid,
   output logic [XCNT_W-1:0] x_count,
   output logic              dbg_state
);
   localparam int            DEPTH    = 2 ** (N_IN + 1);
   localparam logic [N_IN:0] PTR_LAST = '1;
   localparam logic [N_IN:0] PTR_ONE  = (N_IN + 1)'(1);
   localparam logic [1:0]    E_ZERO   = 2'b00;
   localparam logic [1:0]    E_ONE    = 2'b01;
   localparam logic [1:0]    E_X      = 2'b11;

   typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [N_IN:0] ptr_q, ptr_d;
   logic          out_q, out_d;
   logic          out_x_q, out_x_d;
   logic          out_valid_q, out_valid_d;
   logic          cfg_done_q, cfg_done_d;
   logic [1:0]    table_q [DEPTH];
   logic [1:0]    table_d [DEPTH];
   logic [N_IN:0] idx;
   logic [1:0]    entry;

   // Handshake: an entry transfers on a cycle with cfg_valid && cfg_ready && !cfg_start.
   assign cfg_ready = (state_q == S_LOAD);
   assign cfg_done  = cfg_done_q;
   assign out       = out_q;
   assign out_x     = out_x_q;
   assign out_valid = out_valid_q;
   assign dbg_state = (state_q == S_RUN);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      out_d       = out_q;
      out_x_d     = out_x_q;
      out_valid_d = out_valid_q;
      cfg_done_d  = 1'b0;
      table_d     = table_q;
      idx         = {seq_mode ? out_q : 1'b0, in};
      entry       = table_q[idx];
      if (cfg_start) begin
         state_d     = S_LOAD;
         ptr_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               out_valid_d = 1'b0;
               if (cfg_valid) begin
                  table_d[ptr_q] = cfg_data;
                  if (ptr_q == PTR_LAST) begin
                     cfg_done_d = 1'b1;
                     state_d    = S_RUN;
                     ptr_d      = '0;
                  end else begin
                     ptr_d = ptr_q + PTR_ONE;
                  end
               end
            end
            S_RUN: begin
               // Hold ("-") and x entries both leave out untouched.
               if (en) begin
                  if (entry == E_ZERO) out_d = 1'b0;
                  else if (entry == E_ONE) out_d = 1'b1;
                  out_x_d     = (entry == E_X);
                  out_valid_d = 1'b1;
               end
            end
            default: state_d = S_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_LOAD;
         ptr_q       <= '0;
         out_q       <= 1'b0;
         out_x_q     <= 1'b0;
         out_valid_q <= 1'b0;
         cfg_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         out_q       <= out_d;
         out_x_q     <= out_x_d;
         out_valid_q <= out_valid_d;
         cfg_done_q  <= cfg_done_d;
      end
   end

   // Table contents are don't-care after reset; a full load always precedes RUN.
   always_ff @(posedge clk) begin
      table_q <= table_d;
   end

`ifdef UDP_XCOUNT_EN
   localparam logic [XCNT_W-1:0] XCNT_ONE = XCNT_W'(1);
   logic [XCNT_W-1:0] xcnt_q, xcnt_d;
   logic              hit_x;

   assign hit_x = (state_q == S_RUN) && en && !cfg_start && (entry == E_X);

   always_comb begin
      xcnt_d = xcnt_q;
      if (cfg_start) xcnt_d = '0;
      else if (hit_x && (xcnt_q != '1)) xcnt_d = xcnt_q + XCNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) xcnt_q <= '0;
      else     xcnt_q <= xcnt_d;
   end

   assign x_count = xcnt_q;
`else
   assign x_count = '0;
`endif

endmodule

// File: tb/tb_prog_udp_seq.sv
// Bench for prog_udp_seq: per-cycle behavioural model plus directed literal checks and random runs.
module tb_prog_udp_seq;
   localparam int N_IN  = 4;
   localparam int DEPTH = 32;
   localparam int HALF  = 16;
   localparam int XMAX  = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_start = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [1:0] cfg_data = 2'b00;
   logic       cfg_ready, cfg_done;
   logic       seq_mode = 1'b0;
   logic       en = 1'b0;
   logic [3:0] in = 4'h0;
   logic       out, out_x, out_valid, dbg_state;
   logic [7:0] x_count;

   int total = 0;
   int bad   = 0;

   logic [1:0] ld_tab [DEPTH];

   // behavioural model state
   int m_tab [DEPTH];
   int m_ptr = 0;
   bit m_run = 0, m_out = 0, m_x = 0, m_ov = 0, m_done = 0;
   int m_xc = 0;

   prog_udp_seq #(.N_IN(N_IN), .XCNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_ready(cfg_ready), .cfg_done(cfg_done), .seq_mode(seq_mode), .en(en), .in(in),
      .out(out), .out_x(out_x), .out_valid(out_valid), .x_count(x_count), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      int e, idx;
      if (rst) begin
         m_run = 0; m_ptr = 0; m_out = 0; m_x = 0; m_ov = 0; m_done = 0; m_xc = 0;
      end else begin
         m_done = 0;
         if (cfg_start) begin
            m_run = 0; m_ptr = 0; m_ov = 0; m_xc = 0;
         end else if (!m_run) begin
            m_ov = 0;
            if (cfg_valid) begin
               m_tab[m_ptr] = int'(cfg_data);
               if (m_ptr == DEPTH - 1) begin
                  m_done = 1; m_run = 1; m_ptr = 0;
               end else begin
                  m_ptr = m_ptr + 1;
               end
            end
         end else if (en) begin
            idx = int'(in) + ((seq_mode && m_out) ? HALF : 0);
            e = m_tab[idx];
            if (e == 0) m_out = 0;
            else if (e == 1) m_out = 1;
            m_x = (e == 3);
            m_ov = 1;
`ifdef UDP_XCOUNT_EN
            if (e == 3 && m_xc < XMAX) m_xc = m_xc + 1;
`endif
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("out", out, m_out);
      chk("out_x", out_x, m_x);
      chk("out_valid", out_valid, m_ov);
      chk("cfg_done", cfg_done, m_done);
      chk("cfg_ready", cfg_ready, !m_run);
      chk("state", dbg_state, m_run);
      chk("x_count", x_count, m_xc);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic restart();
      cfg_start = 1'b1; cfg_valid = 1'($urandom_range(0, 1)); cfg_data = 2'($urandom_range(0, 3));
      tick();
      cfg_start = 1'b0; cfg_valid = 1'b0;
   endtask

   task automatic load_n(input int n, input bit check_done);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            cfg_valid = 1'b0; cfg_data = 2'($urandom_range(0, 3));
            en = 1'($urandom_range(0, 1)); in = 4'($urandom_range(0, 15));
            tick();
         end
         cfg_valid = 1'b1; cfg_data = ld_tab[i];
         en = 1'($urandom_range(0, 1)); in = 4'($urandom_range(0, 15));
         tick();
         if (check_done) chk((i == DEPTH - 1) ? "done_last" : "done_early", cfg_done, int'(i == DEPTH - 1));
      end
      cfg_valid = 1'b0; en = 1'b0;
   endtask

   task automatic ev(input logic [3:0] v);
      cfg_valid = 1'b0; en = 1'b1; in = v;
      tick();
   endtask

   initial begin
      logic [3:0] pat [8];
      int         exp_out [8];
      bit a, b, c, d;
      pat = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b1001, 4'b1111, 4'b1101, 4'b1000};
      exp_out = '{1, 1, 0, 1, 1, 0, 1, 1};

      repeat (3) tick();
      chk("rst_ready", cfg_ready, 1);
      chk("rst_out", out, 0);
      rst = 1'b0;
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_xcnt", x_count, 0);

      // combinational table: out = ~c | ~d | (a & ~b & c), upper half copies lower half
      for (int i = 0; i < DEPTH; i++) begin
         {a, b, c, d} = 4'(i % HALF);
         ld_tab[i] = (!c || !d || (a && !b && c)) ? 2'b01 : 2'b00;
      end
      seq_mode = 1'b0;
      load_n(DEPTH, 1);
      chk("valid_before_eval", out_valid, 0);
      for (int k = 0; k < 8; k++) begin
         ev(pat[k]);
         chk("comb_out", out, exp_out[k]);
         chk("comb_valid", out_valid, 1);
      end

      // enable low: outputs hold while in toggles
      for (int k = 0; k < 5; k++) begin
         en = 1'b0; in = 4'(k * 3 + 1);
         tick();
         chk("hold_out", out, 1);
         chk("hold_x", out_x, 0);
         chk("hold_valid", out_valid, 1);
      end

      // cfg_start wins over cfg_valid; in=0011 would give 0 if it were evaluated
      cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 2'b11; en = 1'b1; in = 4'b0011;
      tick();
      cfg_start = 1'b0; cfg_valid = 1'b0; en = 1'b0;
      chk("start_state", dbg_state, 0);
      chk("start_ready", cfg_ready, 1);
      chk("start_valid", out_valid, 0);
      chk("start_out_hold", out, 1);

      // sequential latch: in[0] sets, in[1] clears, otherwise hold
      for (int i = 0; i < DEPTH; i++)
         ld_tab[i] = (i % 2 == 1) ? 2'b01 : (((i / 2) % 2 == 1) ? 2'b00 : 2'b10);
      load_n(DEPTH, 1);
      seq_mode = 1'b1;
      ev(4'b0001); chk("seq_set", out, 1);
      ev(4'b0000); chk("seq_hold1", out, 1);
      ev(4'b0010); chk("seq_clr", out, 0);
      ev(4'b0000); chk("seq_hold0", out, 0);

      // x entry at index 5
      restart();
      for (int i = 0; i < DEPTH; i++) ld_tab[i] = (i % HALF == 5) ? 2'b11 : 2'b01;
      seq_mode = 1'b0;
      load_n(DEPTH, 1);
      ev(4'b0000); chk("x_pre_out", out, 1);
      ev(4'b0101);
      chk("x_out", out, 1);
      chk("x_flag", out_x, 1);
`ifdef UDP_XCOUNT_EN
      chk("x_cnt1", x_count, 1);
`else
      chk("x_cnt1", x_count, 0);
`endif
      repeat (299) ev(4'b0101);
`ifdef UDP_XCOUNT_EN
      chk("x_cnt_sat", x_count, 255);
`else
      chk("x_cnt_sat", x_count, 0);
`endif
      ev(4'b0000); chk("x_clear_flag", out_x, 0);

      // reset after 10 of 32 entries, then a full reload
      restart();
      load_n(10, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_out", out, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", cfg_ready, 1);
      chk("mid_rst_xcnt", x_count, 0);
      chk("mid_rst_state", dbg_state, 0);
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) ld_tab[i] = 2'b01;
      load_n(DEPTH, 1);
      ev(4'b1010); chk("reload_out", out, 1);

      // random tables, modes and enables against the model
      for (int r = 0; r < 5; r++) begin
         restart();
         if (r == 2) begin
            load_n(int'($urandom_range(1, DEPTH - 1)), 0);
            restart();
         end
         for (int i = 0; i < DEPTH; i++) ld_tab[i] = 2'($urandom_range(0, 3));
         load_n(DEPTH, 1);
         for (int k = 0; k < 80; k++) begin
            en = 1'($urandom_range(0, 1)); in = 4'($urandom_range(0, 15));
            seq_mode = 1'($urandom_range(0, 1));
            cfg_valid = 1'($urandom_range(0, 1)); cfg_data = 2'($urandom_range(0, 3));
            tick();
         end
         cfg_valid = 1'b0; en = 1'b0;
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/prog_udp_seq.md
Name: prog_udp_seq

Overview:
- Parametrised, run-time-programmable successor to a fixed-table user-defined primitive.
- Holds an N_IN-input truth table in registers, loaded through a valid/ready stream after reset or on request.
- Evaluates the table every enabled clock and registers the result.
- Supports combinational mode and sequential mode; in sequential mode the current output is fed back as an extra table index bit, like a sequential UDP.

Parameters:
- N_IN, 4, number of data inputs (1..6).
- DEPTH, 2**(N_IN+1), table entries; derived, not to be overridden.
- XCNT_W, 8, width of the x-hit counter (optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_start  input  1  pulse; restart table load from entry 0.
- cfg_valid  input  1  table entry present on cfg_data.
- cfg_data  input  2  entry code: 00 = 0, 01 = 1, 10 = hold ("-"), 11 = x.
- cfg_ready  output  1  block accepts an entry this cycle.
- cfg_done  output  1  one-cycle pulse after the last entry is written.
- seq_mode  input  1  1 = sequential (output fed back), 0 = combinational.
- en  input  1  evaluate this cycle.
- in  input  N_IN  data inputs; in[N_IN-1] is the leftmost table column.
- out  output  1  registered result.
- out_x  output  1  last evaluation hit an x entry.
- out_valid  output  1  table loaded and at least one evaluation done.
- x_count  output  XCNT_W  saturating count of x hits.

Behaviour:
- Reset values (asynchronous, on rst=1):
  - state = LOAD, load pointer = 0.
  - out = 0, out_x = 0, out_valid = 0, cfg_done = 0, x_count = 0, cfg_ready = 1.
  - Table contents are not reset (don't care).
- FSM states are LOAD and RUN.
- LOAD state:
  - cfg_ready = 1.
  - Each cycle with cfg_valid=1, table[ptr] <= cfg_data and ptr increments.
  - Entries are written in ascending index order. Index = {state_bit, in}; entries 0..2**N_IN-1 cover state_bit = 0.
  - When the entry at ptr = DEPTH-1 is accepted: cfg_done = 1 on the next cycle, state -> RUN, ptr -> 0.
  - en is ignored; out, out_x and out_valid hold their reset or previous values, except that out_valid is forced to 0.
- RUN state:
  - cfg_ready = 0; cfg_valid is ignored.
  - When en=1: idx = {seq_mode ? out : 1'b0, in}, e = table[idx].
  - Next-cycle update from e:
    - e = 00: out <= 0.
    - e = 01: out <= 1.
    - e = 10: out holds.
    - e = 11: out holds.
  - out_x <= (e == 11). out_valid <= 1.
  - Latency: result on out one clock after the inputs are sampled.
  - When en=0: out, out_x and out_valid hold.
- cfg_start (either state): next cycle state = LOAD, ptr = 0, out_valid = 0.
  - out and out_x hold.
  - cfg_start has priority over a simultaneous cfg_valid; that entry is not written.
- Combinational mode only reads entries 0..2**N_IN-1, but the load still requires all DEPTH entries.
- Hold entries in combinational mode keep the last registered out.
- Changing seq_mode takes effect on the next enabled evaluation; no flush.
- rst asserted mid-load or mid-run returns to LOAD immediately; the partially loaded table must be reloaded in full.

Optional Feature:
- Macro: UDP_XCOUNT_EN.
- Defined:
  - x_count increments by 1 on every enabled RUN evaluation with e = 11.
  - It saturates at 2**XCNT_W-1.
  - It clears on rst or cfg_start.
- Undefined: x_count is tied to 0 and no counter logic is generated.
- The port exists in both builds.

Test Plan:
- Reset, then load 32 entries (N_IN=4) encoding out = ~c | ~d | (a&~b&c), with the upper half a copy of the lower half; seq_mode=0; apply in = 0000, 0001, 0011, 0110, 1001, 1111, 1101, 1000 -> out = 1, 1, 0, 1, 1, 0, 1, 1, each one cycle later. out_valid rises after the first evaluation. cfg_done pulses once, after entry 31.
- Sequential latch: seq_mode=1, table with in[0]=1 -> 1, in[1]=1 -> 0, otherwise 10 (hold). Apply 0001, 0000, 0010, 0000 -> out = 1, 1, 0, 0.
- x entry: table[5] = 11, out previously 1, in = 0101 -> out stays 1, out_x = 1. With UDP_XCOUNT_EN, x_count = 1 after one hit and saturates at 255 after 300 consecutive hits. Without the macro, x_count stays 0.
- cfg_start during RUN with cfg_valid=1 in the same cycle -> state LOAD, ptr = 0, entry not written, out_valid = 0, cfg_ready = 1.
- Assert rst after 10 of 32 entries -> all outputs at reset values. A full reload of 32 entries is required before cfg_done pulses.
- en=0 for 5 cycles while in toggles -> out, out_x and out_valid unchanged.
